// File: rtl/cpu_consts.sv
// Shared types and constants for the load/store sequencer.
// Holds the access-size and LSU state encodings, the strobe patterns,
// and helpers that build byte enables and lane-replicated store data.
package cpu_consts;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Byte enables for an access; the reserved size (2'b11) behaves as a word.
  function automatic logic [3:0] lsu_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      BYTE:      strb = STRB_BYTE << off;
      HALF_WORD: strb = STRB_HALF << {off[1], 1'b0};
      default:   strb = STRB_WORD;
    endcase
    return strb;
  endfunction

  // Copy the stored byte/halfword onto every lane so the strobes alone pick the target.
  function automatic logic [31:0] lsu_replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      BYTE:      data = {4{wdata[7:0]}};
      HALF_WORD: data = {2{wdata[15:0]}};
      default:   data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// raw read word and sign- or zero-extends it. Words pass through unchanged.
module lsu_load_align
  import cpu_consts::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_zero_extnd,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Lane selection and extension of the returned word.
  always_comb begin
    w_byte = i_raw[7:0];
    w_half = i_off[1] ? i_raw[31:16] : i_raw[15:0];
    w_sign = 1'b0;
    o_data = i_raw;
    case (i_off)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
    case (i_size)
      BYTE: begin
        w_sign = ~i_zero_extnd & w_byte[7];
        o_data = {{24{w_sign}}, w_byte};
      end
      HALF_WORD: begin
        w_sign = ~i_zero_extnd & w_half[15];
        o_data = {{16{w_sign}}, w_half};
      end
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the decoder's data-access controls and a
// single-port data-memory bus. One transaction in flight; the pipeline is
// stalled from the request cycle until the access completes.
// Request channel: a request is transferred on a rising edge where
// mem_req_valid_o and mem_req_ready_i are both high; while valid is high and
// ready is low every mem_req_* field is held stable. The response channel is
// valid-only and is only sampled in the RSP state.
// Optional build macro LSU_MISALIGN_TRAP_EN: adds lsu_misalign_o and turns
// misaligned halfword/word accesses into a one-cycle trap with no bus request.
module lsu_ctrl
  import cpu_consts::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_data_req_i,
  input  logic              ex_data_wr_i,
  input  logic [1:0]        ex_data_byte_i,
  input  logic              ex_zero_extnd_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              lsu_stall_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rdata_valid_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_wr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [3:0]        mem_req_strb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_rdata_i,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              lsu_misalign_o,
`endif
  output lsu_state_t        dbg_state_o
);

  lsu_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_wr;
  logic              r_zext;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_strb;
  logic              r_req_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_misalign;
  logic [DATA_W-1:0] w_load_data;
  logic              w_misalign;
  logic              w_stall;

  lsu_load_align u_align (
    .i_raw        (mem_rsp_rdata_i),
    .i_off        (r_addr[1:0]),
    .i_size       (r_size),
    .i_zero_extnd (r_zext),
    .o_data       (w_load_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment is judged on the incoming request, before anything is captured.
  always_comb begin
    w_misalign = ((ex_data_byte_i == HALF_WORD) && ex_addr_i[0]) ||
                 ((ex_data_byte_i == WORD) && (ex_addr_i[1:0] != 2'b00));
  end
`else
  // Without the trap, misaligned accesses silently truncate the low address bits.
  always_comb begin
    w_misalign = 1'b0;
  end
`endif

  // Stall covers the request cycle itself plus REQ and RSP; DONE releases it.
  always_comb begin
    w_stall = ~reset & (((r_state == IDLE) & ex_data_req_i) |
                        (r_state == REQ) | (r_state == RSP));
  end

  // Sequencer FSM with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_size        <= 2'b00;
      r_wr          <= 1'b0;
      r_zext        <= 1'b0;
      r_wdata       <= '0;
      r_strb        <= 4'b0000;
      r_req_valid   <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdata_valid <= 1'b0;
          r_misalign    <= 1'b0;
          if (ex_data_req_i) begin
            r_addr  <= ex_addr_i;
            r_size  <= ex_data_byte_i;
            r_wr    <= ex_data_wr_i;
            r_zext  <= ex_zero_extnd_i;
            r_wdata <= lsu_replicate(ex_data_byte_i, ex_wdata_i);
            r_strb  <= lsu_strobe(ex_data_byte_i, ex_addr_i[1:0]);
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_req_valid <= 1'b1;
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= r_wr ? DONE : RSP;
          end
        end
        RSP: begin
          if (mem_rsp_valid_i) begin
            r_rdata       <= w_load_data;
            r_rdata_valid <= 1'b1;
            r_state       <= DONE;
          end
        end
        DONE: begin
          // The decoder still presents the finishing instruction here, so its request is ignored.
          r_rdata_valid <= 1'b0;
          r_misalign    <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu_stall_o       = w_stall;
  assign lsu_rdata_o       = r_rdata;
  assign lsu_rdata_valid_o = r_rdata_valid;
  assign mem_req_valid_o   = r_req_valid;
  assign mem_req_addr_o    = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_req_wr_o      = r_wr;
  assign mem_req_wdata_o   = r_wdata;
  assign mem_req_strb_o    = r_strb;
  assign dbg_state_o       = r_state;
`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu_misalign_o    = r_misalign;
`else
  // Misalign flag is only observable when the trap is built in.
  logic w_unused_misalign;
  assign w_unused_misalign = r_misalign;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with an arithmetic reference model and a
// per-cycle compare process. Define LSU_MISALIGN_TRAP_EN to cover the trap build.
module tb_lsu_ctrl;
  import cpu_consts::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_data_req_i, ex_data_wr_i, ex_zero_extnd_i;
  logic [1:0]  ex_data_byte_i;
  logic [31:0] ex_addr_i, ex_wdata_i;
  logic        lsu_stall_o, lsu_rdata_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_wr_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_strb_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_rdata_i;
  lsu_state_t  dbg_state_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        lsu_misalign_o;
`endif

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_data_req_i     (ex_data_req_i),
    .ex_data_wr_i      (ex_data_wr_i),
    .ex_data_byte_i    (ex_data_byte_i),
    .ex_zero_extnd_i   (ex_zero_extnd_i),
    .ex_addr_i         (ex_addr_i),
    .ex_wdata_i        (ex_wdata_i),
    .lsu_stall_o       (lsu_stall_o),
    .lsu_rdata_o       (lsu_rdata_o),
    .lsu_rdata_valid_o (lsu_rdata_valid_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_req_addr_o    (mem_req_addr_o),
    .mem_req_wr_o      (mem_req_wr_o),
    .mem_req_wdata_o   (mem_req_wdata_o),
    .mem_req_strb_o    (mem_req_strb_o),
    .mem_rsp_valid_i   (mem_rsp_valid_i),
    .mem_rsp_rdata_i   (mem_rsp_rdata_i),
`ifdef LSU_MISALIGN_TRAP_EN
    .lsu_misalign_o    (lsu_misalign_o),
`endif
    .dbg_state_o       (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  logic chk_en = 1'b0;
  logic exp_stall = 1'b0, exp_req_valid = 1'b0, exp_rdv = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_hold = 32'h0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  logic        m_wr;
  logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
  logic [3:0]  cap_strb = 4'h0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int m_off(input logic [1:0] sz, input logic [31:0] a);
    int nb = m_bytes(sz);
    return (nb == 4) ? 0 : ((a % 4) / nb) * nb;
  endfunction

  function automatic logic [3:0] m_strobe(input logic [1:0] sz, input logic [31:0] a);
    int v = ((1 << m_bytes(sz)) - 1) << m_off(sz, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_repl(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r = 32'h0;
    int nb = m_bytes(sz);
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic zx,
                                         input logic [31:0] a, input logic [31:0] raw);
    int nb = m_bytes(sz);
    longint v;
    if (nb == 4) return raw;
    v = (longint'(raw) >> (8 * m_off(sz, a))) & ((64'sd1 << (8 * nb)) - 1);
    if (!zx && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic m_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_stall_len(input logic mis, input logic wr, input int rdly, input int rspd);
    return mis ? 1 : 1 + rdly + 1 + (wr ? 0 : rspd);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("req_valid", {31'b0, mem_req_valid_o}, {31'b0, exp_req_valid});
      chk("stall", {31'b0, lsu_stall_o}, {31'b0, exp_stall});
      chk("rdata_valid", {31'b0, lsu_rdata_valid_o}, {31'b0, exp_rdv});
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misalign", {31'b0, lsu_misalign_o}, {31'b0, exp_mis});
`endif
      if (mem_req_valid_o && exp_req_valid) begin
        cap_addr = mem_req_addr_o; cap_strb = mem_req_strb_o; cap_wdata = mem_req_wdata_o;
        chk("req_addr", mem_req_addr_o, m_addr);
        chk("req_strb", {28'b0, mem_req_strb_o}, {28'b0, m_strb});
        chk("req_wr", {31'b0, mem_req_wr_o}, {31'b0, m_wr});
        if (m_wr) chk("req_wdata", mem_req_wdata_o, m_wdata);
      end
      if (exp_rdv) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL exp_q: load completed with empty expected queue");
        end else exp_hold = exp_q.pop_front();
      end
      chk("rdata", lsu_rdata_o, exp_hold);
      if (lsu_stall_o) stall_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic access(input logic wr, input logic [1:0] sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rdly, input int rspd, input logic [31:0] raw);
    logic mis;
    mis     = m_misalign(sz, a);
    m_addr  = a & ~32'h3;
    m_strb  = m_strobe(sz, a);
    m_wdata = m_repl(sz, wd);
    m_wr    = wr;
    if (!wr && !mis) exp_q.push_back(m_load(sz, zx, a, raw));
    stall_cnt = 0;
    ex_data_req_i = 1'b1; ex_data_wr_i = wr; ex_data_byte_i = sz;
    ex_zero_extnd_i = zx; ex_addr_i = a; ex_wdata_i = wd;
    exp_stall = 1'b1; exp_req_valid = 1'b0; exp_rdv = 1'b0;
    tick();
    if (mis) begin
      exp_stall = 1'b0; exp_mis = 1'b1;
      tick();
      exp_mis = 1'b0; ex_data_req_i = 1'b0;
      tick();
    end else begin
      exp_req_valid = 1'b1;
      repeat (rdly) begin
        mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = $urandom;  // must be ignored outside RSP
        tick();
      end
      mem_rsp_valid_i = 1'b0;
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0; exp_req_valid = 1'b0;
      if (!wr) begin
        repeat (rspd - 1) tick();
        mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = raw;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = $urandom;
        exp_rdv = 1'b1;
      end
      exp_stall = 1'b0;
      tick();
      ex_data_req_i = 1'b0; exp_rdv = 1'b0;
      tick();
    end
    chk("stall_len", stall_cnt, m_stall_len(mis, wr, rdly, rspd));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    ex_data_req_i = 1'b0; ex_data_wr_i = 1'b0; ex_data_byte_i = 2'b00;
    ex_zero_extnd_i = 1'b0; ex_addr_i = 32'h0; ex_wdata_i = 32'h0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_state", {30'b0, dbg_state_o}, {30'b0, IDLE});
    chk("rst_valid", {31'b0, mem_req_valid_o}, 32'h0);
    chk("rst_stall", {31'b0, lsu_stall_o}, 32'h0);
    chk("rst_addr", mem_req_addr_o, 32'h0);
    chk("rst_strb", {28'b0, mem_req_strb_o}, 32'h0);
    chk("rst_rdata", lsu_rdata_o, 32'h0);
    chk_en = 1'b1;
    tick();

    // SW 0x100
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_strb", {28'b0, cap_strb}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_stall", stall_cnt, 2);
    // SB 0x103
    access(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 0, 0, 32'h0);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_strb", {28'b0, cap_strb}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    // LB / LBU 0x101
    access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, 1, 32'h000080FF);
    chk("lb_rdata", lsu_rdata_o, 32'hFFFFFF80);
    chk("lb_stall", stall_cnt, 3);
    access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 1, 32'h000080FF);
    chk("lbu_rdata", lsu_rdata_o, 32'h00000080);
    // LH 0x102, slow ready and slow response
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 3, 2, 32'h9ABC1234);
    chk("lh_rdata", lsu_rdata_o, 32'hFFFF9ABC);
    chk("lh_stall", stall_cnt, 7);
    // Further patterns
    access(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 1, 0, 32'h0);
    chk("sh_strb", {28'b0, cap_strb}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'h12341234);
    access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 3, 32'h9ABC8001);
    chk("lhu_rdata", lsu_rdata_o, 32'h00008001);
    access(1'b1, 2'b00, 1'b0, 32'h201, 32'h12345677, 2, 0, 32'h0);
    chk("sb1_strb", {28'b0, cap_strb}, 32'h2);
    access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 0, 1, 32'h7F00FFFF);
    chk("lb3_rdata", lsu_rdata_o, 32'h0000007F);
    access(1'b1, 2'b11, 1'b0, 32'h301, 32'hCAFEF00D, 0, 0, 32'h0);
    chk("rsv_strb", {28'b0, cap_strb}, 32'hF);
    access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1, 1, 32'h89ABCDEF);
    chk("lw_rdata", lsu_rdata_o, 32'h89ABCDEF);
    // Misaligned LW 0x102 and SH 0x101
    access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lw_stall", stall_cnt, 1);
    chk("mis_lw_rdata", lsu_rdata_o, 32'h89ABCDEF);
`else
    chk("mis_lw_addr", cap_addr, 32'h100);
    chk("mis_lw_rdata", lsu_rdata_o, 32'h11223344);
`endif
    access(1'b1, 2'b01, 1'b0, 32'h105, 32'h0000BEEF, 0, 0, 32'h0);

    // Reset while waiting in RSP, then a late response
    m_addr = 32'h400; m_strb = 4'h1; m_wr = 1'b0; m_wdata = 32'h0;
    ex_data_req_i = 1'b1; ex_data_wr_i = 1'b0; ex_data_byte_i = 2'b00;
    ex_zero_extnd_i = 1'b0; ex_addr_i = 32'h400;
    exp_stall = 1'b1;
    tick();
    exp_req_valid = 1'b1; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; exp_req_valid = 1'b0;
    chk("pre_rst_state", {30'b0, dbg_state_o}, {30'b0, RSP});
    reset = 1'b1; ex_data_req_i = 1'b0;
    tick();
    reset = 1'b0; exp_stall = 1'b0; exp_hold = 32'h0;
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h000000FF;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("late_rsp_state", {30'b0, dbg_state_o}, {30'b0, IDLE});
    chk("late_rsp_rdv", {31'b0, lsu_rdata_valid_o}, 32'h0);
    chk("late_rsp_rdata", lsu_rdata_o, 32'h0);
    repeat (2) tick();
    chk("final_state", {30'b0, dbg_state_o}, {30'b0, IDLE});
    chk("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: bench did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
